// File: rtl/spi_slave_burst_if.sv
// Register-bank port between the SPI slave and a single-cycle register bank.
//   bus_addr  : register address driven by the SPI slave
//   bus_wdata : write data
//   bus_we    : one-cycle write strobe
//   bus_re    : one-cycle read strobe
//   bus_rdata : read data returned by the bank one clk after bus_re
// Modports: master = SPI slave side, slave = register bank side.
interface spi_slave_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_re,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        input  bus_re,
        output bus_rdata
    );
endinterface

// File: rtl/spi_slave_burst.sv
// SPI slave that turns SPI frames into register-bank accesses.
// Frame: 8-bit command (bit7 = write, low bits = start address) followed by
// any number of DATA_W-bit words, auto-incrementing the address per word.
// SPI pins are oversampled in the clk domain; mode {CPOL,CPHA} is latched
// when ss falls.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   sclk, ss, mosi: SPI pins (asynchronous to clk)
//   miso, miso_oe : SPI data out and its pad enable (registered)
//   mode          : {CPOL,CPHA}, sampled at frame start
//   bus           : register-bank port (master modport)
//   busy          : frame in progress
//   frame_done    : pulse when a frame ends on a word boundary
//   frame_err     : pulse when a frame ends mid-word
module spi_slave_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     ss,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     miso_oe,
    input  logic [1:0]               mode,
    spi_slave_burst_if.master        bus,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_err
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Synchroniser chains: [1] is the synchronised value, [2] the previous one.
    // ss resets low so a select already asserted when reset releases never
    // looks like a falling edge.
    logic [2:0] sclk_sync_r, ss_sync_r, mosi_sync_r;
    logic       sclk_rise_r, sclk_fall_r, ss_rise_r, ss_fall_r;

    state_t              state_r, state_n;
    logic                cpol_r, cpol_n, cpha_r, cpha_n;
    logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_n;
    logic [DATA_W-2:0]   rx_sr_r, rx_sr_n;
    logic [DATA_W-1:0]   tx_sr_r, tx_sr_n;
    logic [DATA_W-1:0]   tx_buf_r, tx_buf_n;
    logic                is_write_r, is_write_n;
    logic [ADDR_W-1:0]   addr_r, addr_n;
    logic [DATA_W-1:0]   wdata_r, wdata_n;
    logic                we_r, we_n, re_r, re_n, cap_r;
    logic                miso_r, miso_n, oe_r, oe_n, busy_r, busy_n;
    logic                done_r, done_n, err_r, err_n;

    logic                mosi_bit_s, lead_s, trail_s, sample_s, shift_s;
    logic [DATA_W-1:0]   word_s;

    assign mosi_bit_s = mosi_sync_r[2];
    assign lead_s     = cpol_r ? sclk_fall_r : sclk_rise_r;
    assign trail_s    = cpol_r ? sclk_rise_r : sclk_fall_r;
    assign sample_s   = cpha_r ? trail_s : lead_s;
    assign shift_s    = cpha_r ? lead_s  : trail_s;
    assign word_s     = {rx_sr_r, mosi_bit_s};

    // Pin synchronisers and registered edge detectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= 3'b000;
            ss_sync_r   <= 3'b000;
            mosi_sync_r <= 3'b000;
            sclk_rise_r <= 1'b0;
            sclk_fall_r <= 1'b0;
            ss_rise_r   <= 1'b0;
            ss_fall_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], sclk};
            ss_sync_r   <= {ss_sync_r[1:0], ss};
            mosi_sync_r <= {mosi_sync_r[1:0], mosi};
            sclk_rise_r <= sclk_sync_r[1] & ~sclk_sync_r[2];
            sclk_fall_r <= ~sclk_sync_r[1] & sclk_sync_r[2];
            ss_rise_r   <= ss_sync_r[1] & ~ss_sync_r[2];
            ss_fall_r   <= ~ss_sync_r[1] & ss_sync_r[2];
        end
    end

    // Next-state and output decode for the frame FSM and its datapath.
    always_comb begin
        state_n    = state_r;
        cpol_n     = cpol_r;
        cpha_n     = cpha_r;
        bit_cnt_n  = bit_cnt_r;
        rx_sr_n    = rx_sr_r;
        tx_sr_n    = tx_sr_r;
        is_write_n = is_write_r;
        addr_n     = addr_r;
        wdata_n    = wdata_r;
        we_n       = 1'b0;
        re_n       = 1'b0;
        miso_n     = miso_r;
        oe_n       = oe_r;
        busy_n     = busy_r;
        done_n     = 1'b0;
        err_n      = 1'b0;

        // Read data arrives one clk after the read strobe.
        if (cap_r) begin
            tx_buf_n = bus.bus_rdata;
        end else begin
            tx_buf_n = tx_buf_r;
        end

        // A write advances the address the cycle after its strobe.
        if (we_r) begin
            addr_n = addr_r + ADDR_W'(1'b1);
        end else begin
            addr_n = addr_r;
        end

        case (state_r)
            ST_IDLE: begin
                miso_n = 1'b0;
                oe_n   = 1'b0;
                busy_n = 1'b0;
                if (ss_fall_r) begin
                    state_n   = ST_CMD;
                    cpol_n    = mode[1];
                    cpha_n    = mode[0];
                    bit_cnt_n = '0;
                    busy_n    = 1'b1;
                    oe_n      = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CMD, ST_DATA: begin
                // ss release wins over any sclk edge seen in the same cycle.
                if (ss_rise_r) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    oe_n    = 1'b0;
                    miso_n  = 1'b0;
                    if (bit_cnt_r == '0) begin
                        done_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (sample_s) begin
                    rx_sr_n = word_s[DATA_W-2:0];
                    if (state_r == ST_CMD) begin
                        if (bit_cnt_r == CNT_W'(3'd7)) begin
                            addr_n     = ADDR_W'(word_s[7:0]);
                            is_write_n = word_s[7];
                            re_n       = ~word_s[7];
                            bit_cnt_n  = '0;
                            state_n    = ST_DATA;
                        end else begin
                            bit_cnt_n = bit_cnt_r + CNT_W'(1'b1);
                        end
                    end else begin
                        if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_n = '0;
                            if (is_write_r) begin
                                we_n    = 1'b1;
                                wdata_n = word_s;
                            end else begin
                                // Prefetch the next word at the next address.
                                addr_n = addr_r + ADDR_W'(1'b1);
                                re_n   = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_r + CNT_W'(1'b1);
                        end
                    end
                end else if (shift_s) begin
                    if (state_r == ST_DATA && !is_write_r) begin
                        // Bit counter at 0 on a shift edge means a new word's
                        // MSB goes out, so reload from the prefetched buffer.
                        if (bit_cnt_r == '0) begin
                            miso_n  = tx_buf_r[DATA_W-1];
                            tx_sr_n = {tx_buf_r[DATA_W-2:0], 1'b0};
                        end else begin
                            miso_n  = tx_sr_r[DATA_W-1];
                            tx_sr_n = {tx_sr_r[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        miso_n = 1'b0;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                oe_n    = 1'b0;
                miso_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            bit_cnt_r  <= '0;
            rx_sr_r    <= '0;
            tx_sr_r    <= '0;
            tx_buf_r   <= '0;
            is_write_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            we_r       <= 1'b0;
            re_r       <= 1'b0;
            cap_r      <= 1'b0;
            miso_r     <= 1'b0;
            oe_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            cpol_r     <= cpol_n;
            cpha_r     <= cpha_n;
            bit_cnt_r  <= bit_cnt_n;
            rx_sr_r    <= rx_sr_n;
            tx_sr_r    <= tx_sr_n;
            tx_buf_r   <= tx_buf_n;
            is_write_r <= is_write_n;
            addr_r     <= addr_n;
            wdata_r    <= wdata_n;
            we_r       <= we_n;
            re_r       <= re_n;
            cap_r      <= re_r;
            miso_r     <= miso_n;
            oe_r       <= oe_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
            err_r      <= err_n;
        end
    end

    assign miso          = miso_r;
    assign miso_oe       = oe_r;
    assign busy          = busy_r;
    assign frame_done    = done_r;
    assign frame_err     = err_r;
    assign bus.bus_addr  = addr_r;
    assign bus.bus_wdata = wdata_r;
    assign bus.bus_we    = we_r;
    assign bus.bus_re    = re_r;
endmodule

// File: tb/tb_spi_slave_burst.sv
// Self-checking bench for spi_slave_burst (DATA_W=32, ADDR_W=6).
// A behavioural SPI master drives frames; a register bank model answers
// reads; a monitor logs bus strobes and frame pulses.
module tb_spi_slave_burst;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int H  = 8;   // sclk half-period in clk cycles

    logic clk = 1'b0;
    logic rst, sclk, ss, mosi, miso, miso_oe, busy, frame_done, frame_err;
    logic [1:0] mode;

    always #5 clk = ~clk;

    spi_slave_burst_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if();

    spi_slave_burst #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mode(mode), .bus(bus_if),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    // Register bank: single-cycle, read data registered one clk after bus_re.
    logic [DW-1:0] bank [0:63];
    logic [DW-1:0] bank_rdata;
    logic          init_bank;
    always @(posedge clk) begin
        if (init_bank) begin
            for (int i = 0; i < 64; i++) bank[i] <= 32'hA000_0000 | 32'(i);
        end else if (bus_if.bus_we === 1'b1) begin
            bank[bus_if.bus_addr] <= bus_if.bus_wdata;
        end
        if (bus_if.bus_re === 1'b1) bank_rdata <= bank[bus_if.bus_addr];
    end
    assign bus_if.bus_rdata = bank_rdata;

    // Monitor of strobes and frame pulses.
    logic [37:0] we_q[$];
    logic [5:0]  re_q[$];
    int done_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    always @(negedge clk) begin
        if (bus_if.bus_we === 1'b1) we_q.push_back({bus_if.bus_addr, bus_if.bus_wdata});
        if (bus_if.bus_re === 1'b1) re_q.push_back(bus_if.bus_addr);
        if (bus_if.bus_we === 1'b1 && bus_if.bus_re === 1'b1) overlap_cnt++;
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    int checks = 0, failures = 0;
    logic [DW-1:0] tx_words [0:3];
    logic [DW-1:0] rx_words [0:3];
    logic [DW-1:0] ref_mem  [0:63];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] cmd;
        int         nw;
        int         extra;
        logic [31:0] w0, w1;
        int         exp_nwe, exp_nre;
        logic [5:0] exp_a0, exp_a1, exp_a2;
        logic [31:0] exp_d0, exp_d1;
        int         exp_done, exp_err;
    } vec_t;
    vec_t vecs [0:4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic cpol, input logic cpha, input logic b, output logic mb);
        if (!cpha) begin
            mosi = b; wait_clk(H);
            sclk = ~cpol; mb = miso; wait_clk(H);
            sclk = cpol;
        end else begin
            sclk = ~cpol; mosi = b; wait_clk(H);
            sclk = cpol; mb = miso; wait_clk(H);
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [7:0] cmd, input int nw, input int extra);
        logic mb;
        logic [DW-1:0] acc;
        acc = '0;
        mode = m; sclk = m[1]; wait_clk(8);
        ss = 1'b0; wait_clk(H);
        for (int b = 7; b >= 0; b--) spi_bit(m[1], m[0], cmd[b], mb);
        chk("busy_oe_in_frame", 64'({busy, miso_oe}), 64'd3);
        for (int w = 0; w < nw; w++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                spi_bit(m[1], m[0], tx_words[w][b], mb);
                acc[b] = mb;
            end
            rx_words[w] = acc;
        end
        for (int b = 0; b < extra; b++) spi_bit(m[1], m[0], tx_words[nw][DW-1-b], mb);
        wait_clk(H); ss = 1'b1; wait_clk(12);
        chk("idle_after_frame", 64'({busy, miso_oe}), 64'd0);
    endtask

    // Reference model: expected bus traffic and miso words from the frame intent.
    task automatic check_model(input logic [7:0] cmd, input int nw, input int extra,
                               input int we_b, input int re_b, input int dn_b, input int er_b);
        logic [5:0] start;
        start = cmd[5:0];
        if (cmd[7]) begin
            chk("model_n_we", 64'(we_q.size() - we_b), 64'(nw));
            chk("model_n_re", 64'(re_q.size() - re_b), 64'd0);
            for (int i = 0; i < nw; i++) begin
                if (we_b + i < we_q.size())
                    chk("model_we", 64'(we_q[we_b+i]), 64'({6'(start + i), tx_words[i]}));
                ref_mem[6'(start + i)] = tx_words[i];
            end
        end else begin
            chk("model_n_we", 64'(we_q.size() - we_b), 64'd0);
            chk("model_n_re", 64'(re_q.size() - re_b), 64'(nw + 1));
            for (int i = 0; i <= nw; i++)
                if (re_b + i < re_q.size())
                    chk("model_re_addr", 64'(re_q[re_b+i]), 64'(6'(start + i)));
            for (int i = 0; i < nw; i++)
                chk("model_miso_word", 64'(rx_words[i]), 64'(ref_mem[6'(start + i)]));
        end
        chk("model_done", 64'(done_cnt - dn_b), 64'((extra == 0) ? 1 : 0));
        chk("model_err", 64'(err_cnt - er_b), 64'((extra != 0) ? 1 : 0));
    endtask

    initial begin
        int we_b, re_b, dn_b, er_b;
        logic mb;
        logic [1:0] m;
        logic [7:0] cmd;
        int nw, extra;

        rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; mode = 2'd0; init_bank = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA000_0000 | 32'(i);
        wait_clk(5);
        chk("reset_outputs", 64'({miso, miso_oe, busy, bus_if.bus_we, bus_if.bus_re,
                                 frame_done, frame_err, bus_if.bus_addr, bus_if.bus_wdata}), 64'd0);
        init_bank = 1'b0;
        rst = 1'b0;
        wait_clk(10);

        // Directed vectors from the test plan.
        vecs[0] = '{2'd0, 8'h85, 2, 0,  32'h1111_1111, 32'h2222_2222, 2, 0, 6'd5,  6'd6, 6'd0,
                    32'h1111_1111, 32'h2222_2222, 1, 0};
        vecs[1] = '{2'd3, 8'h3F, 2, 0,  32'h0, 32'h0, 0, 3, 6'd63, 6'd0, 6'd1,
                    32'hA000_003F, 32'hA000_0000, 1, 0};
        vecs[2] = '{2'd1, 8'h83, 1, 0,  32'hDEAD_BEEF, 32'h0, 1, 0, 6'd3, 6'd0, 6'd0,
                    32'hDEAD_BEEF, 32'h0, 1, 0};
        vecs[3] = '{2'd2, 8'h83, 1, 0,  32'hDEAD_BEEF, 32'h0, 1, 0, 6'd3, 6'd0, 6'd0,
                    32'hDEAD_BEEF, 32'h0, 1, 0};
        vecs[4] = '{2'd0, 8'h82, 0, 17, 32'h5A5A_5A5A, 32'h0, 0, 0, 6'd0, 6'd0, 6'd0,
                    32'h0, 32'h0, 0, 1};

        for (int v = 0; v < 5; v++) begin
            tx_words[0] = vecs[v].w0; tx_words[1] = vecs[v].w1; tx_words[2] = 32'h0F0F_0F0F;
            we_b = we_q.size(); re_b = re_q.size(); dn_b = done_cnt; er_b = err_cnt;
            run_frame(vecs[v].mode, vecs[v].cmd, vecs[v].nw, vecs[v].extra);
            chk("vec_n_we", 64'(we_q.size() - we_b), 64'(vecs[v].exp_nwe));
            chk("vec_n_re", 64'(re_q.size() - re_b), 64'(vecs[v].exp_nre));
            if (vecs[v].exp_nwe > 0 && we_q.size() > we_b)
                chk("vec_we0", 64'(we_q[we_b]), 64'({vecs[v].exp_a0, vecs[v].exp_d0}));
            if (vecs[v].exp_nwe > 1 && we_q.size() > we_b + 1)
                chk("vec_we1", 64'(we_q[we_b+1]), 64'({vecs[v].exp_a1, vecs[v].exp_d1}));
            if (vecs[v].exp_nre > 2 && re_q.size() > re_b + 2) begin
                chk("vec_re0", 64'(re_q[re_b]),   64'(vecs[v].exp_a0));
                chk("vec_re1", 64'(re_q[re_b+1]), 64'(vecs[v].exp_a1));
                chk("vec_re2", 64'(re_q[re_b+2]), 64'(vecs[v].exp_a2));
                chk("vec_miso0", 64'(rx_words[0]), 64'(vecs[v].exp_d0));
                chk("vec_miso1", 64'(rx_words[1]), 64'(vecs[v].exp_d1));
            end
            chk("vec_done", 64'(done_cnt - dn_b), 64'(vecs[v].exp_done));
            chk("vec_err", 64'(err_cnt - er_b), 64'(vecs[v].exp_err));
            if (vecs[v].cmd[7])
                for (int i = 0; i < vecs[v].nw; i++) ref_mem[6'(vecs[v].cmd[5:0] + i)] = tx_words[i];
        end

        // Idle noise: sclk toggling with ss high must do nothing.
        we_b = we_q.size(); re_b = re_q.size(); dn_b = done_cnt; er_b = err_cnt;
        for (int i = 0; i < 12; i++) begin
            sclk = ~sclk; mosi = 1'($urandom); wait_clk(4);
        end
        wait_clk(6);
        chk("noise_status", 64'({busy, miso_oe}), 64'd0);
        chk("noise_strobes", 64'((we_q.size() - we_b) + (re_q.size() - re_b)), 64'd0);
        chk("noise_pulses", 64'((done_cnt - dn_b) + (err_cnt - er_b)), 64'd0);
        tx_words[0] = 32'h1357_9BDF;
        we_b = we_q.size(); re_b = re_q.size(); dn_b = done_cnt; er_b = err_cnt;
        run_frame(2'd0, 8'h8A, 1, 0);
        check_model(8'h8A, 1, 0, we_b, re_b, dn_b, er_b);

        // Reset in the middle of a write word, then ss held low across release.
        we_b = we_q.size(); re_b = re_q.size(); dn_b = done_cnt; er_b = err_cnt;
        tx_words[0] = 32'h1234_5678;
        mode = 2'd0; sclk = 1'b0; wait_clk(8); ss = 1'b0; wait_clk(H);
        for (int b = 7; b >= 0; b--) spi_bit(1'b0, 1'b0, b == 7 || b == 0, mb);
        for (int b = 31; b > 11; b--) spi_bit(1'b0, 1'b0, tx_words[0][b], mb);
        rst = 1'b1;
        wait_clk(1);
        chk("rst_mid_frame_outputs", 64'({miso, miso_oe, busy, bus_if.bus_we, bus_if.bus_re,
                                         frame_done, frame_err, bus_if.bus_addr, bus_if.bus_wdata}), 64'd0);
        wait_clk(2); rst = 1'b0;
        for (int b = 0; b < 12; b++) spi_bit(1'b0, 1'b0, 1'b1, mb);
        wait_clk(4);
        chk("rst_ss_low_ignored", 64'({busy, miso_oe}), 64'd0);
        ss = 1'b1; wait_clk(12);
        chk("rst_no_we", 64'(we_q.size() - we_b), 64'd0);
        chk("rst_no_pulses", 64'((done_cnt - dn_b) + (err_cnt - er_b)), 64'd0);
        tx_words[0] = 32'hCAFE_F00D;
        we_b = we_q.size(); re_b = re_q.size(); dn_b = done_cnt; er_b = err_cnt;
        run_frame(2'd0, 8'h81, 1, 0);
        check_model(8'h81, 1, 0, we_b, re_b, dn_b, er_b);

        // Randomised frames against the reference model.
        for (int f = 0; f < 20; f++) begin
            m     = 2'($urandom_range(0, 3));
            cmd   = 8'($urandom);
            nw    = $urandom_range(0, 2);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
            for (int i = 0; i < 4; i++) tx_words[i] = $urandom;
            we_b = we_q.size(); re_b = re_q.size(); dn_b = done_cnt; er_b = err_cnt;
            run_frame(m, cmd, nw, extra);
            check_model(cmd, nw, extra, we_b, re_b, dn_b, er_b);
        end

        chk("we_re_never_together", 64'(overlap_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_burst.md
# spi_slave_burst

Parametrised SPI slave that turns SPI frames into register-bank accesses. It supports all four SPI modes, selected per frame, and configurable data and address widths. Multi-word burst reads and writes use an auto-incrementing address. The block oversamples the SPI pins in the system clock domain and drives a simple single-cycle register-bank port, so it replaces the front-end/protocol pair in front of a register bank.

## Interface
Parameters:
- DATA_W, 32, data word width in bits (8..64).
- ADDR_W, 6, register address width (1..7).

Ports:
- clk  in  1  system clock; must be at least 8× the sclk frequency.
- rst  in  1  reset, asynchronous, active-high.
- sclk  in  1  SPI clock, asynchronous to clk.
- ss  in  1  slave select, active-low, asynchronous.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out.
- miso_oe  out  1  output enable for the miso pad; 1 while a frame is active.
- mode  in  2  {CPOL,CPHA}; captured when ss falls, ignored mid-frame.
- bus_addr  out  ADDR_W  register address.
- bus_wdata  out  DATA_W  write data.
- bus_we  out  1  one-cycle write strobe.
- bus_re  out  1  one-cycle read strobe.
- bus_rdata  in  DATA_W  read data, valid exactly 1 clk after bus_re.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when ss rises on a word boundary.
- frame_err  out  1  one-cycle pulse when ss rises mid-word.

## Operation
Synchronisation and edges:
- sclk, ss and mosi each pass through a 2-FF synchroniser.
- Edge detection on the synchronised sclk and ss adds 1 cycle.
- Leading edge = first sclk transition away from CPOL level; trailing edge = return to it.
- CPHA=0: sample on leading edge, shift on trailing edge. CPHA=1: shift on leading edge, sample on trailing edge.
- All bits are MSB first.

Frame format:
- 8-bit command word, then N ≥ 0 data words of DATA_W bits.
- Command bit7=1 means write, 0 means read; bits[ADDR_W-1:0] give the start address; remaining bits are ignored.

States:
- IDLE:
  - miso=0, miso_oe=0, busy=0.
  - sclk edges are ignored.
  - ss falling → CMD; mode is latched, the bit counter is cleared, busy=1, miso_oe=1.
- CMD:
  - shift 8 bits in; miso=0 throughout.
  - On the 8th sample, bus_addr ← start address.
  - Read command: bus_re pulses the next cycle; bus_rdata is captured into the tx buffer 1 cycle later.
  - → DATA.
- DATA:
  - Shift DATA_W bits per word.
  - Write: when the last bit of a word is sampled, the next cycle asserts bus_we with bus_wdata = word and the current bus_addr. The cycle after that, bus_addr increments.
  - Read: on each shift edge the shift register outputs its next bit. The shift edge that presents a word's MSB first loads the tx buffer.
    - CPHA=0: that edge is the trailing edge of the previous word's last bit (or of command bit 8).
    - CPHA=1: that edge is the leading edge of the word's first bit.
  - Read, at each completed word: bus_addr increments, bus_re pulses the next cycle (prefetch), and the tx buffer is refilled.
  - Reads are prefetched, so one extra read past the final word always occurs.
- Address wraps from 2^ADDR_W−1 to 0.
- ss rising, any non-IDLE state → IDLE:
  - On a word boundary (bit counter 0, state DATA, or CMD with 0 bits): frame_done pulses.
  - Otherwise frame_err pulses and the partial word is discarded (no bus_we).
- ss rising and an sclk edge in the same cycle: ss takes priority and the edge is ignored.
- rst asserted mid-frame: immediate return to IDLE with all outputs at reset values; no strobes. After rst releases, a new frame starts only on a fresh ss falling edge (an ss already low is ignored).

## Timing
- Reset values: miso=0, miso_oe=0, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, busy=0, frame_done=0, frame_err=0.
- Pin-to-internal-edge latency: 3 clk cycles.
- miso changes 1 clk after the internal shift edge (registered output).
- Write: bus_we asserts 1 clk after the internal sample edge of the last bit of the word.
- Read: bus_re pulses 1 clk after the internal sample edge of the last bit of the command or word; data is captured into the tx buffer 2 clk after that sample edge. With sclk half-period ≥ 4 clk this precedes the next shift edge.
- bus_we and bus_re are never asserted in the same cycle.
- frame_done and frame_err assert 1 clk after the internal ss rising edge, together with busy→0 and miso_oe→0.

## Test plan
- Reset: assert rst mid-frame → all outputs at reset values within 1 clk; no bus_we; the next frame decodes correctly.
- Mode 0 write burst: cmd 0x85, data 0x11111111, 0x22222222 (ADDR_W=6) → bus_we at addr 5 then 6 with those values; frame_done=1.
- Mode 3 read burst with wrap: cmd 0x3F, 2 words, rdata = 0xA0000000|addr → miso returns 0xA000003F then 0xA0000000; bus_re at addr 63, 0, 1.
- Mode 1/2 alternation: a frame in mode 1 then a frame in mode 2, each writing 0xDEADBEEF to addr 3 → both produce an identical bus_we.
- Abort: cmd 0x82 then ss rises after 17 data bits → frame_err pulse; no bus_we.
- Idle noise: sclk toggling with ss high → no strobes, busy=0, miso_oe=0; a following frame is decoded correctly.
